// File: rtl/ram_stream_reader_pkg.sv
// Shared state encoding and output-FIFO sizing
// for the RAM-to-stream burst reader.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Four-entry output FIFO holding {last, data} beats
// between the RAM read pipeline and the stream port.
module stream_fifo4
    import ram_stream_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (count != FIFO_FULL);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a synchronous RAM port
// and replays them as a valid/ready stream with tlast.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic [DWIDTH-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    state_t              state_q;
    state_t              state_d;
    logic [AWIDTH-1:0]   addr_q;
    logic [AWIDTH:0]     rem_q;
    logic [RD_LAT-1:0]   vld_sr;
    logic [RD_LAT-1:0]   last_sr;
    logic                done_q;
    logic                done_d;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_valid;
    logic [DWIDTH:0]     fifo_dout;
    logic                issue;
    logic                last_issue;
    logic                pop;
    logic                tlast_hs;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + CNT_W'(vld_sr[i]);
    end

    // Credit check keeps every issued read guaranteed a FIFO slot
    assign issue      = (state_q == RUN) &&
                        ((inflight + fifo_cnt) < FIFO_FULL);
    assign last_issue = issue && (rem_q == (AWIDTH+1)'(1));
    assign pop        = fifo_valid && m_tready;
    assign tlast_hs   = pop && fifo_dout[DWIDTH];

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ram_en   = busy;
    assign ram_we   = 1'b0;
    assign ram_addr = addr_q;
    assign m_tvalid = fifo_valid;
    assign m_tdata  = fifo_dout[DWIDTH-1:0];
    assign m_tlast  = fifo_valid && fifo_dout[DWIDTH];

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) state_d = RUN;
                    else           done_d  = 1'b1;
                end
            end
            RUN: begin
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                if (tlast_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == IDLE && start) begin
                addr_q <= base_addr;
                rem_q  <= len;
            end else if (issue) begin
                addr_q <= addr_q + AWIDTH'(1);
                rem_q  <= rem_q - (AWIDTH+1)'(1);
            end
            vld_sr[0]  <= issue;
            last_sr[0] <= last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    stream_fifo4 #(
        .W(DWIDTH + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (vld_sr[RD_LAT-1]),
        .din  ({last_sr[RD_LAT-1], ram_dout}),
        .pop  (pop),
        .dout (fifo_dout),
        .valid(fifo_valid),
        .count(fifo_cnt)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench driving one RD_LAT=1 and one RD_LAT=2 reader in
// lockstep against a word-list model of each burst.
module tb_ram_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    typedef struct {
        int            cyc;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_tready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;

    logic          busy0, done0, en0, we0, tv0, tl0;
    logic [AW-1:0] ra0;
    logic [DW-1:0] rd0, td0;
    logic          busy1, done1, en1, we1, tv1, tl1;
    logic [AW-1:0] ra1;
    logic [DW-1:0] rd1, td1, r1a;

    logic [DW-1:0] mem [DEPTH];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            rmode = 0;
    beat_t         bq [2][$];
    logic [AW-1:0] alog [2][$];

    logic          mon_v [2], mon_l [2], mon_dn [2], mon_b [2], mon_e [2];
    logic [DW-1:0] mon_d [2];
    logic [AW-1:0] mon_a [2];
    logic          hs_prev [2], z_prev [2], st_prev [2], l_prev [2];
    logic [DW-1:0] d_prev [2];

    ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len(len), .busy(busy0), .done(done0), .ram_en(en0),
        .ram_we(we0), .ram_addr(ra0), .ram_dout(rd0), .m_tdata(td0),
        .m_tvalid(tv0), .m_tready(m_tready), .m_tlast(tl0)
    );

    ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len(len), .busy(busy1), .done(done1), .ram_en(en1),
        .ram_we(we1), .ram_addr(ra1), .ram_dout(rd1), .m_tdata(td1),
        .m_tvalid(tv1), .m_tready(m_tready), .m_tlast(tl1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (en0) rd0 <= mem[ra0];

    always @(posedge clk) begin
        if (en1) begin
            r1a <= mem[ra1];
            rd1 <= r1a;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hs_prev[i] = 1'b0;
            z_prev[i]  = 1'b0;
            st_prev[i] = 1'b0;
        end
    end

    // Monitor: done timing, stall stability, beat and address capture
    always @(negedge clk) begin
        mon_v[0] = tv0;  mon_v[1] = tv1;
        mon_l[0] = tl0;  mon_l[1] = tl1;
        mon_d[0] = td0;  mon_d[1] = td1;
        mon_dn[0] = done0; mon_dn[1] = done1;
        mon_b[0] = busy0; mon_b[1] = busy1;
        mon_e[0] = en0;  mon_e[1] = en1;
        mon_a[0] = ra0;  mon_a[1] = ra1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("done_timing%0d", i), mon_dn[i],
                !rst && (hs_prev[i] || z_prev[i]));
            if (!rst && st_prev[i]) begin
                chk($sformatf("stall_valid%0d", i), mon_v[i], 1);
                chk($sformatf("stall_data%0d", i), mon_d[i], d_prev[i]);
                chk($sformatf("stall_last%0d", i), mon_l[i], l_prev[i]);
            end
            if (!rst && mon_v[i] && m_tready)
                bq[i].push_back('{cyc, mon_l[i], mon_d[i]});
            if (!rst && mon_e[i] &&
                (alog[i].size() == 0 || alog[i][$] != mon_a[i]))
                alog[i].push_back(mon_a[i]);
            hs_prev[i] = !rst && mon_v[i] && m_tready && mon_l[i];
            z_prev[i]  = !rst && start && (len == 0) && !mon_b[i];
            st_prev[i] = !rst && mon_v[i] && !m_tready;
            d_prev[i]  = mon_d[i];
            l_prev[i]  = mon_l[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rmode == 0)      m_tready = 1'b1;
        else if (rmode == 1) m_tready = (cyc % 4 == 0);
        else                 m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_burst(input int b, input int l, output int s);
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start     = 1'b1;
        step();
        s     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit s0 = 0;
        bit s1 = 0;
        int n  = 0;
        while (!(s0 && s1) && n < 600) begin
            step();
            n++;
            if (done0 && !s0) begin
                s0 = 1;
                chk({tag, "_busy_at_done0"}, busy0, 0);
            end
            if (done1 && !s1) begin
                s1 = 1;
                chk({tag, "_busy_at_done1"}, busy1, 0);
            end
        end
        chk({tag, "_done_seen"}, s0 && s1, 1);
    endtask

    // Expected beat k of a burst is mem[(base+k) mod depth]
    task automatic check_burst(input string tag, input int b,
                               input int l, input int s, input bit timed);
        beat_t bt;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_count%0d", tag, i), bq[i].size(), l);
            for (int k = 0; k < l && bq[i].size() > 0; k++) begin
                bt = bq[i].pop_front();
                chk($sformatf("%s_data%0d_%0d", tag, i, k), bt.data,
                    mem[(b + k) % DEPTH]);
                chk($sformatf("%s_last%0d_%0d", tag, i, k), bt.last,
                    (k == l - 1));
                if (timed)
                    chk($sformatf("%s_edge%0d_%0d", tag, i, k), bt.cyc,
                        s + (i + 1) + 1 + k);
            end
            bq[i].delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_en0"}, en0, 0);
        chk({tag, "_en1"}, en1, 0);
        chk({tag, "_tvalid0"}, tv0, 0);
        chk({tag, "_tvalid1"}, tv1, 0);
        chk({tag, "_tlast0"}, tl0, 0);
        chk({tag, "_tlast1"}, tl1, 0);
        chk({tag, "_addr0"}, ra0, 0);
        chk({tag, "_addr1"}, ra1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, n, b, l;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

        rst = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        chk("reset_we0", we0, 0);
        chk("reset_we1", we1, 0);
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_reset_tvalid0", tv0, 0);
            chk("post_reset_tvalid1", tv1, 0);
        end

        rmode = 0;
        start_burst(16'h010, 4, s);
        wait_done("basic");
        alog[0].delete();
        alog[1].delete();
        start_burst(16'h1FE, 4, s2);
        check_burst("basic", 16'h010, 4, s, 1);
        wait_done("wrap");
        check_burst("wrap", 16'h1FE, 4, s2, 1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wrap_addrs%0d", i), alog[i].size() >= 4, 1);
            for (int k = 0; k < 4 && k < alog[i].size(); k++)
                chk($sformatf("wrap_addr%0d_%0d", i, k), alog[i][k],
                    (16'h1FE + k) % DEPTH);
        end

        start_burst(0, 8, s);
        wait_done("lat");
        check_burst("lat", 0, 8, s, 1);

        rmode = 1;
        start_burst(16'h080, 16, s);
        wait_done("stall");
        check_burst("stall", 16'h080, 16, s, 0);

        rmode = 0;
        step();
        start_burst(16'h033, 0, s);
        chk("zero_done0", done0, 1);
        chk("zero_done1", done1, 1);
        chk("zero_busy0", busy0, 0);
        repeat (6) begin
            step();
            chk("zero_tvalid0", tv0, 0);
            chk("zero_tvalid1", tv1, 0);
            chk("zero_busy1", busy1, 0);
        end
        chk("zero_beats0", bq[0].size(), 0);

        start_burst(16'h100, 6, s);
        step();
        step();
        base_addr = 9'h1F0;
        len       = 10'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignore");
        check_burst("ignore", 16'h100, 6, s, 1);
        repeat (4) step();
        chk("ignore_extra0", bq[0].size(), 0);
        chk("ignore_extra1", bq[1].size(), 0);
        chk("ignore_idle0", busy0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            rmode = t % 3;
            b = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, 24));
            start_burst(b, l, s);
            wait_done("rand");
            check_burst($sformatf("rand%0d", t), b, l, s, rmode == 0);
        end

        rmode = 0;
        step();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) ^ 32'hA5A5_0000;
        start_burst(16'h040, 10, s);
        n = 0;
        while (bq[0].size() < 3 && n < 50) begin
            step();
            n++;
        end
        chk("midrst_three_beats", bq[0].size(), 3);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        step();
        step();
        rst = 1'b0;
        bq[0].delete();
        bq[1].delete();
        repeat (4) begin
            step();
            chk("after_rst_tvalid0", tv0, 0);
            chk("after_rst_tvalid1", tv1, 0);
        end
        start_burst(16'h020, 2, s);
        wait_done("rerun");
        check_burst("rerun", 16'h020, 2, s, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
